tick_timer: RTL and testbench
=============================

TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100_000_000; input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1; tick rate in Hz.
REQ-003 Parameter CNT_W, default 8; width of the countdown counter, in tick units.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sync_clear  input  1  synchronous restart of the prescaler phase.
REQ-007 pause  input  1  freezes the prescaler and the countdown while high.
REQ-008 load  input  1  one-cycle strobe that starts a countdown.
REQ-009 load_value  input  CNT_W  countdown length in ticks, sampled when load=1.
REQ-010 enable_tick  output  1  one-cycle enable pulse at TICK_HZ.
REQ-011 count  output  CNT_W  remaining ticks.
REQ-012 busy  output  1  high while a countdown is in progress.
REQ-013 expired  output  1  one-cycle pulse when a countdown reaches zero.

Function
REQ-014 Divisor DIV SHALL equal CLK_FREQ_HZ/TICK_HZ; elaboration SHALL fail if DIV<2 or the division has a remainder.
REQ-015 Prescaler SHALL count 0..DIV-1 and wrap to 0; enable_tick SHALL be high exactly in cycles where prescaler==DIV-1 and pause==0.
REQ-016 pause=1 SHALL hold the prescaler, count and FSM state; enable_tick and expired SHALL stay 0 during pause.
REQ-017 sync_clear=1 SHALL force the prescaler to 0 at the next edge, with no enable_tick in that cycle; sync_clear SHALL NOT affect count or busy.
REQ-018 FSM states SHALL be IDLE (busy=0), RUN (busy=1) and HOLD (busy=1, entered from RUN while pause=1, left when pause=0).
REQ-019 load=1 with load_value!=0, in any state, SHALL set count=load_value, prescaler=0 and state=RUN at the next edge.
REQ-020 load=1 with load_value==0 SHALL set count=0 and state=IDLE, and SHALL pulse expired in the following cycle.
REQ-021 In RUN, each enable_tick SHALL decrement count at the same edge; the 1->0 transition SHALL set state=IDLE and assert expired for exactly the next cycle.
REQ-022 Latency: after a load of N at edge 0 with no pause, count SHALL reach 0 and expired SHALL assert at edge N*DIV.
REQ-023 load coincident with enable_tick SHALL give load priority, with no decrement.
REQ-024 load coincident with pause SHALL perform the load; the FSM SHALL enter HOLD instead of RUN.
REQ-025 In IDLE, the prescaler and enable_tick SHALL keep running; count SHALL never underflow.

Reset
REQ-026 reset_n=0 SHALL asynchronously set prescaler=0, count=0, state=IDLE, enable_tick=0, busy=0 and expired=0.
REQ-027 Reset mid-countdown SHALL abandon the countdown without an expired pulse.
REQ-028 Reset release SHALL be synchronised by the upstream reset bridge; the first enable_tick SHALL occur DIV cycles after the first active edge.

Configuration
REQ-029 Macro TICK_TIMER_FAST_SIM_EN defined: DIV SHALL be forced to 10, regardless of the parameters.
REQ-030 Macro TICK_TIMER_FAST_SIM_EN undefined: DIV SHALL follow REQ-014.

Structure
REQ-031 Package tick_timer_pkg SHALL hold the FSM state typedef (IDLE/RUN/HOLD), the DIV computation function and the FAST_SIM divisor constant.
REQ-032 Prescaler and enable_tick generation SHALL be a sub-module named tick_prescaler (ports clock, reset_n, sync_clear, hold, enable_tick).
REQ-033 tick_timer SHALL contain the FSM and the countdown register only.

Verification
REQ-034 FAST_SIM, no load, 100 cycles after reset -> enable_tick pulses at cycles 10, 20, ..., 100, each 1 cycle wide.
REQ-035 FAST_SIM, load_value=3 at edge 0 -> count 3,2,1,0 at edges 0,10,20,30; expired high for 1 cycle after edge 30; busy falls at edge 30.
REQ-036 FAST_SIM, load 5, pause high for 25 cycles from edge 12 -> expired delayed by exactly 25 cycles (edge 75); no ticks while paused.
REQ-037 Reload with 2 during the 7-tick countdown, coinciding with enable_tick -> count=2 with no decrement; expired 20 cycles later; single expired pulse only.
REQ-038 load_value=0 -> expired pulse next cycle; busy stays 0.
REQ-039 reset_n low mid-countdown (count=4) -> all outputs 0 immediately, asynchronously; no expired pulse after release.

Source files
------------

// File: rtl/tick_timer_pkg.sv
// Shared definitions for tick_timer: state encoding, divisor math and the
// fixed divisor used when TICK_TIMER_FAST_SIM_EN is defined.
package tick_timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam int unsigned FAST_SIM_DIV = 10;

  function automatic int unsigned calcDiv(input int unsigned clkHz,
                                          input int unsigned tickHz);
    if (tickHz == 0) return 0;
    return clkHz / tickHz;
  endfunction

  // A usable divisor must be exact and at least 2 so the tick stays one cycle wide.
  function automatic bit divValid(input int unsigned clkHz,
                                  input int unsigned tickHz);
    if (tickHz == 0) return 1'b0;
    if ((clkHz % tickHz) != 0) return 1'b0;
    return (clkHz / tickHz) >= 2;
  endfunction

endpackage

// File: rtl/tick_timer_prescaler.sv
// Free-running prescaler for tick_timer: counts 0..DIV-1 and flags the last phase.
// sync_clear restarts the phase; suppressing the tick during a clear is left to the parent.
module tick_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sync_clear,
  input  logic hold,
  output logic enable_tick
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] r_presc;

  // Clear wins over hold so a restart issued during pause still takes effect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (sync_clear) begin
      r_presc <= '0;
    end else if (!hold) begin
      r_presc <= (r_presc == LAST) ? '0 : r_presc + ONE;
    end
  end

  assign enable_tick = (r_presc == LAST) && !hold;

endmodule

// File: rtl/tick_timer.sv
// Tick-based countdown timer: prescaled enable tick plus a loadable countdown FSM.
// Define TICK_TIMER_FAST_SIM_EN to force the divisor to 10 for fast simulation.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sync_clear,
  input  logic             pause,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             enable_tick,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             expired
);

`ifdef TICK_TIMER_FAST_SIM_EN
  localparam int unsigned DIV = FAST_SIM_DIV;
`else
  localparam int unsigned DIV = calcDiv(CLK_FREQ_HZ, TICK_HZ);

  if (!divValid(CLK_FREQ_HZ, TICK_HZ)) begin : g_bad_div
    $error("tick_timer: CLK_FREQ_HZ/TICK_HZ must divide exactly and give at least 2");
  end
`endif

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             w_tick_raw;
  logic             w_presc_clear;
  logic             w_busy;
  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_expired;

  // A load restarts the tick phase so a countdown of N lasts exactly N*DIV cycles.
  assign w_presc_clear = sync_clear | load;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clock       (clock),
    .reset_n     (reset_n),
    .sync_clear  (w_presc_clear),
    .hold        (pause),
    .enable_tick (w_tick_raw)
  );

  assign enable_tick = w_tick_raw & ~sync_clear;
  assign w_busy      = (r_state != ST_IDLE);

  // Load beats everything; pause freezes count and any pending expiry pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_expired <= 1'b0;
    end else if (load) begin
      r_count <= load_value;
      if (load_value != '0) begin
        r_state   <= pause ? ST_HOLD : ST_RUN;
        r_expired <= 1'b0;
      end else begin
        r_state   <= ST_IDLE;
        r_expired <= 1'b1;
      end
    end else if (pause) begin
      if (r_state == ST_RUN) r_state <= ST_HOLD;
    end else begin
      r_expired <= 1'b0;
      if (r_state == ST_HOLD) r_state <= ST_RUN;
      if (w_busy && enable_tick && (r_count != '0)) begin
        r_count <= r_count - ONE;
        if (r_count == ONE) begin
          r_state   <= ST_IDLE;
          r_expired <= 1'b1;
        end
      end
    end
  end

  assign count   = r_count;
  assign busy    = w_busy;
  assign expired = r_expired & ~pause;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: vector table, directed multi-cycle cases
// and a randomized run against a tick-counting reference model.
module tb_tick_timer;

  localparam int unsigned CLK_HZ  = 10;
  localparam int unsigned TICK_HZ = 1;
  localparam int          CNT_W   = 8;
  localparam int          DIV     = 10;

  typedef struct {
    bit               sc;
    bit               p;
    bit               ld;
    logic [CNT_W-1:0] lv;
    logic [CNT_W-1:0] eCount;
    bit               eBusy;
    bit               eExp;
    bit               eTick;
  } vec_t;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             syncClear;
  logic             pause;
  logic             load;
  logic [CNT_W-1:0] loadValue;
  logic             enableTick;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             expired;

  int total = 0;
  int bad   = 0;

  // Reference model: phase of the tick divider, ticks seen since the last load.
  int mPhase;
  int mLoaded;
  int mTicks;
  bit mRunning;
  bit mExpPending;

  logic             seenTick;
  logic             seenBusy;
  logic             seenExp;
  logic [CNT_W-1:0] seenCount;

  vec_t vecs[14];

  always #5 clock = ~clock;

  tick_timer #(
    .CLK_FREQ_HZ (CLK_HZ),
    .TICK_HZ     (TICK_HZ),
    .CNT_W       (CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sync_clear  (syncClear),
    .pause       (pause),
    .load        (load),
    .load_value  (loadValue),
    .enable_tick (enableTick),
    .count       (count),
    .busy        (busy),
    .expired     (expired)
  );

  task automatic modelReset();
    mPhase      = 0;
    mLoaded     = 0;
    mTicks      = 0;
    mRunning    = 1'b0;
    mExpPending = 1'b0;
  endtask

  task automatic modelStep();
    bit tick;
    if (!reset_n) begin
      modelReset();
      return;
    end
    tick = (mPhase == DIV - 1) && !pause && !syncClear;
    if (load) begin
      mLoaded     = int'(loadValue);
      mTicks      = 0;
      mPhase      = 0;
      mRunning    = (loadValue != '0);
      mExpPending = (loadValue == '0);
    end else begin
      if (syncClear) mPhase = 0;
      else if (!pause) mPhase = (mPhase + 1) % DIV;
      if (!pause) begin
        mExpPending = 1'b0;
        if (mRunning && tick) begin
          mTicks++;
          if (mTicks == mLoaded) begin
            mRunning    = 1'b0;
            mExpPending = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput(input string name);
    logic             eTick;
    logic             eBusy;
    logic             eExp;
    logic [CNT_W-1:0] eCount;
    eTick  = (mPhase == DIV - 1) && !pause && !syncClear && reset_n;
    eCount = CNT_W'(mLoaded - mTicks);
    eBusy  = mRunning;
    eExp   = mExpPending && !pause;
    total++;
    if ({enableTick, count, busy, expired} !== {eTick, eCount, eBusy, eExp}) begin
      bad++;
      $display("[TB] FAIL %s t=%0t: got tick=%b count=%0d busy=%b expired=%b, want tick=%b count=%0d busy=%b expired=%b",
               name, $time, enableTick, count, busy, expired, eTick, eCount, eBusy, eExp);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int want);
    total++;
    if (actual != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, want);
    end
  endtask

  task automatic applyStimulus(input bit sc, input bit p, input bit ld,
                               input logic [CNT_W-1:0] lv, input string name);
    @(negedge clock);
    syncClear = sc;
    pause     = p;
    load      = ld;
    loadValue = lv;
    #1;
    seenTick  = enableTick;
    seenBusy  = busy;
    seenExp   = expired;
    seenCount = count;
    checkOutput(name);
    @(posedge clock);
    modelStep();
  endtask

  task automatic doReset();
    @(negedge clock);
    reset_n   = 1'b0;
    syncClear = 1'b0;
    pause     = 1'b0;
    load      = 1'b0;
    loadValue = '0;
    modelReset();
    #1;
    checkOutput("reset_state");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int e;
    int ticks;
    int firstTick;
    int lastTick;
    int adjacent;
    int pulses;
    int firstExp;
    int guard;
    bit prevTick;
    bit pauseState;

    reset_n   = 1'b0;
    syncClear = 1'b0;
    pause     = 1'b0;
    load      = 1'b0;
    loadValue = '0;
    modelReset();

    // {sync_clear, pause, load, load_value, count, busy, expired, enable_tick}
    vecs[0]  = '{0, 0, 0, 8'd0, 8'd0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 8'd0, 8'd0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 8'd0, 8'd0, 0, 1, 0};
    vecs[3]  = '{0, 0, 1, 8'd2, 8'd0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 8'd0, 8'd2, 1, 0, 0};
    vecs[5]  = '{0, 1, 0, 8'd0, 8'd2, 1, 0, 0};
    vecs[6]  = '{1, 0, 0, 8'd0, 8'd2, 1, 0, 0};
    vecs[7]  = '{0, 0, 1, 8'd0, 8'd2, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 8'd0, 8'd0, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 8'd0, 8'd0, 0, 1, 0};
    vecs[10] = '{0, 0, 0, 8'd0, 8'd0, 0, 0, 0};
    vecs[11] = '{0, 1, 1, 8'd1, 8'd0, 0, 0, 0};
    vecs[12] = '{0, 1, 0, 8'd0, 8'd1, 1, 0, 0};
    vecs[13] = '{0, 0, 0, 8'd0, 8'd1, 1, 0, 0};

    $display("[TB] vector table");
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].sc, vecs[i].p, vecs[i].ld, vecs[i].lv, $sformatf("vec%0d_model", i));
      total++;
      if ({seenTick, seenCount, seenBusy, seenExp} !==
          {vecs[i].eTick, vecs[i].eCount, vecs[i].eBusy, vecs[i].eExp}) begin
        bad++;
        $display("[TB] FAIL vec%0d: got tick=%b count=%0d busy=%b expired=%b, want tick=%b count=%0d busy=%b expired=%b",
                 i, seenTick, seenCount, seenBusy, seenExp,
                 vecs[i].eTick, vecs[i].eCount, vecs[i].eBusy, vecs[i].eExp);
      end
    end

    $display("[TB] free-running ticks after reset");
    doReset();
    ticks = 0; firstTick = -1; lastTick = -1; adjacent = 0; prevTick = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      applyStimulus(0, 0, 0, '0, "idle_ticks");
      if (seenTick) begin
        ticks++;
        if (firstTick < 0) firstTick = c;
        lastTick = c;
        if (prevTick) adjacent++;
      end
      prevTick = seenTick;
    end
    checkValue("tick_count_100", ticks, 10);
    checkValue("first_tick_cycle", firstTick, DIV);
    checkValue("last_tick_cycle", lastTick, 100);
    checkValue("tick_width", adjacent, 0);

    $display("[TB] load 3 latency");
    doReset();
    applyStimulus(0, 0, 1, 8'd3, "load3");
    e = 0;
    applyStimulus(0, 0, 0, '0, "run3");
    checkValue("load3_first_count", int'(seenCount), 3);
    while (!seenExp && e < 200) begin
      e++;
      applyStimulus(0, 0, 0, '0, "run3");
    end
    checkValue("load3_expire_edge", e, 30);
    checkValue("load3_busy_at_expire", int'(seenBusy), 0);
    applyStimulus(0, 0, 0, '0, "after3");
    checkValue("load3_expire_width", int'(seenExp), 0);

    $display("[TB] load 5 with 25-cycle pause");
    doReset();
    applyStimulus(0, 0, 1, 8'd5, "load5");
    e = 0; ticks = 0; pulses = 0;
    applyStimulus(0, 0, 0, '0, "pause_run");
    while (!seenExp && e < 300) begin
      e++;
      applyStimulus(0, (e >= 12 && e < 37), 0, '0, "pause_run");
      if (pause && seenTick) ticks++;
    end
    checkValue("pause_expire_edge", e, 75);
    checkValue("pause_ticks", ticks, 0);

    $display("[TB] reload on tick");
    doReset();
    applyStimulus(0, 0, 1, 8'd7, "load7");
    guard = 0;
    while (!(mPhase == DIV - 1 && (mLoaded - mTicks) <= 5) && guard < 200) begin
      guard++;
      applyStimulus(0, 0, 0, '0, "run7");
    end
    applyStimulus(0, 0, 1, 8'd2, "reload2");
    checkValue("reload_on_tick", int'(seenTick), 1);
    pulses = 0; firstExp = -1;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(0, 0, 0, '0, "run2");
      if (k == 0) checkValue("reload_count", int'(seenCount), 2);
      if (seenExp) begin
        pulses++;
        if (firstExp < 0) firstExp = k;
      end
    end
    checkValue("reload_expire_edge", firstExp, 20);
    checkValue("reload_expire_pulses", pulses, 1);

    $display("[TB] async reset mid-countdown");
    doReset();
    applyStimulus(0, 0, 1, 8'd5, "load5r");
    guard = 0;
    while ((mLoaded - mTicks) != 4 && guard < 200) begin
      guard++;
      applyStimulus(0, 0, 0, '0, "run5r");
    end
    #1;
    checkOutput("pre_reset");
    checkValue("pre_reset_count", int'(count), 4);
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    checkValue("async_reset_outputs", int'({enableTick, count, busy, expired}), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      applyStimulus(0, 0, 0, '0, "post_reset");
      if (seenExp) pulses++;
    end
    checkValue("post_reset_expired", pulses, 0);

    $display("[TB] randomized run");
    doReset();
    pauseState = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      bit sc;
      bit ld;
      logic [CNT_W-1:0] lv;
      if ($urandom_range(0, 15) == 0) pauseState = !pauseState;
      sc = ($urandom_range(0, 19) == 0);
      ld = ($urandom_range(0, 24) == 0);
      lv = CNT_W'($urandom_range(0, 4));
      applyStimulus(sc, pauseState, ld, lv, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
